clock_core: RTL and testbench
=============================

// Module: clock_core
// PURPOSE
//  Timekeeping and time-setting core of the multi-mode clock. Derives a 1 s
//  tick from clk, keeps hour:minute:second in binary, and runs a set-mode
//  state machine driven by two pre-debounced button pulses. Sits directly
//  upstream of the 7-segment display stage: drives its cur_time and
//  per-field flash inputs, plus a seconds pulse for the alarm logic.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per second; must be >= 2
//  PS_W           $clog2(TICKS_PER_SEC)  prescaler width; localparam, not overridable
// PORTS
//  clk           in   1   system clock; all logic on rising edge
//  rst_n         in   1   synchronous reset, active low
//  mode_btn      in   1   one-cycle pulse: advance set-mode state
//  inc_btn       in   1   one-cycle pulse: increment the field being set
//  cur_time      out  24  [23:16] hour 0-23, [15:8] min 0-59, [7:0] sec 0-59, binary
//  hour_flash    out  1   high while hours are being set
//  minute_flash  out  1   high while minutes are being set
//  second_flash  out  1   high while seconds are being set
//  sec_pulse     out  1   one-cycle pulse on every running-mode seconds advance
// BEHAVIOUR
//  Reset (rst_n low at an edge)
//   - state=RUN, cur_time=24'h0, prescaler=0.
//   - All flash outputs 0; sec_pulse 0.
//   - Applies from any state, including mid-set.
//  States: RUN -> SET_H -> SET_M -> SET_S -> RUN; each advance on a mode_btn edge.
//  Prescaler (RUN only)
//   - Counts 0..TICKS_PER_SEC-1.
//   - On the edge where it equals TICKS_PER_SEC-1:
//     - prescaler <= 0.
//     - seconds advance, sec_pulse <= 1 for exactly that next cycle.
//   - Period is exactly TICKS_PER_SEC cycles.
//  Seconds advance with carry
//   - sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
//   - All fields update on the same edge.
//  Entering SET_H: prescaler cleared and held at 0 for all SET_* states.
//  Return to RUN: first advance occurs TICKS_PER_SEC cycles later.
//  SET_x + inc_btn
//   - Selected field +1 mod its range (24/60/60).
//   - NO carry into other fields.
//   - Time is otherwise frozen; sec_pulse stays 0.
//  inc_btn in RUN: ignored.
//  mode_btn and inc_btn high on the same edge: mode wins, inc dropped.
//  Inputs held high are treated as one press per cycle (caller must pulse).
//  Flash outputs
//   - Registered decode of the state; change on the same edge as the state.
//   - At most one flash output is high at any time.
//  Value ranges
//   - Unused upper bits are always 0: hour[7:5], min[7:6], sec[7:6].
//   - Out-of-range values are unreachable.
//  Exiting SET_S: all set values are kept; counting resumes from them.
// TESTING  (TICKS_PER_SEC=4)
//  - Reset, run 12 cycles:
//    - cur_time 0x000000 -> 0x000003.
//    - sec_pulse high 3 times, 4 cycles apart.
//    - Flash outputs all 0.
//  - Set 23:59:59 (mode, 23 inc, mode, 59 inc, mode, 59 inc, mode), then 4 cycles:
//    - cur_time = 0x173B3B -> 0x000000 with one sec_pulse.
//  - In SET_M from 05:10:00, 60 inc pulses:
//    - minute returns to 10, hour stays 5.
//    - 50 inc pulses: minute=0, hour still 5 (no carry).
//  - 4 mode pulses with idle gaps:
//    - flashes hour -> minute -> second -> none.
//    - cur_time constant and sec_pulse 0 throughout set mode.
//  - In SET_H, mode_btn and inc_btn on the same cycle:
//    - state SET_M (minute_flash=1), hour unchanged.
//  - rst_n low for 1 cycle while in SET_M with time 0x020300:
//    - Next cycle: cur_time=0, all flashes 0, state RUN.
//    - First sec_pulse 4 cycles after reset release.

Source files
------------

// File: rtl/clock_core.sv
// Timekeeping and time-setting core: 1 s prescaler, binary hh:mm:ss with carry,
// and a four-state set-mode FSM driven by pre-debounced mode/inc pulses.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_RUN   | prescaler counting, time advances once per second
// ST_SET_H | prescaler held at 0, inc_btn steps hours (mod 24)
// ST_SET_M | prescaler held at 0, inc_btn steps minutes (mod 60)
// ST_SET_S | prescaler held at 0, inc_btn steps seconds (mod 60)
module clock_core #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_btn,
  input  logic        inc_btn,
  output logic [23:0] cur_time,
  output logic        hour_flash,
  output logic        minute_flash,
  output logic        second_flash,
  output logic        sec_pulse
);

  localparam int PS_W = $clog2(TICKS_PER_SEC);
  localparam logic [PS_W-1:0] PS_TC = PS_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            hflash_q, hflash_d;
  logic            mflash_q, mflash_d;
  logic            sflash_q, sflash_d;
  logic            pulse_q, pulse_d;
  logic            tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      ps_q     <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      hflash_q <= 1'b0;
      mflash_q <= 1'b0;
      sflash_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      hflash_q <= hflash_d;
      mflash_q <= mflash_d;
      sflash_q <= sflash_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    tick    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (ps_q == PS_TC) begin
          ps_d = '0;
          tick = 1'b1;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
        // A tick coinciding with entry to set mode still lands; the prescaler restarts from 0.
        if (mode_btn) begin
          state_d = ST_SET_H;
          ps_d    = '0;
        end
      end
      ST_SET_H: begin
        if (mode_btn)     state_d = ST_SET_M;
        else if (inc_btn) hour_d  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
      ST_SET_M: begin
        if (mode_btn)     state_d = ST_SET_S;
        else if (inc_btn) min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
      ST_SET_S: begin
        if (mode_btn)     state_d = ST_RUN;
        else if (inc_btn) sec_d   = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      end
      default: state_d = ST_RUN;
    endcase

    if (tick) begin
      pulse_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Flashes decode the next state so they switch on the same edge as the state.
  always_comb begin
    hflash_d = (state_d == ST_SET_H);
    mflash_d = (state_d == ST_SET_M);
    sflash_d = (state_d == ST_SET_S);
  end

  assign cur_time     = {3'b000, hour_q, 2'b00, min_q, 2'b00, sec_q};
  assign hour_flash   = hflash_q;
  assign minute_flash = mflash_q;
  assign second_flash = sflash_q;
  assign sec_pulse    = pulse_q;

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core with TICKS_PER_SEC=4: a vector table for the
// run/set walk-through plus hand sequences for wrap, no-carry and reset cases.
module tb_clock_core;

  logic        clk;
  logic        rst_n;
  logic        mode_btn;
  logic        inc_btn;
  logic [23:0] cur_time;
  logic        hour_flash;
  logic        minute_flash;
  logic        second_flash;
  logic        sec_pulse;

  int n_cmp = 0;
  int n_err = 0;

  clock_core #(.TICKS_PER_SEC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_btn     (mode_btn),
    .inc_btn      (inc_btn),
    .cur_time     (cur_time),
    .hour_flash   (hour_flash),
    .minute_flash (minute_flash),
    .second_flash (second_flash),
    .sec_pulse    (sec_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        inc;
    logic [23:0] t;
    logic [2:0]  fl;
    logic        p;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic m, input logic i, input logic [23:0] t,
                              input logic [2:0] fl, input logic p);
    vec_t v;
    v.mode = m; v.inc = i; v.t = t; v.fl = fl; v.p = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] flashes();
    return {hour_flash, minute_flash, second_flash};
  endfunction

  task automatic cyc(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    @(posedge clk);
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b1);
      check("set_no_pulse", {31'd0, sec_pulse}, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_time",  {8'd0, cur_time}, 32'd0);
    check("rst_flash", {29'd0, flashes()}, 32'd0);
    check("rst_pulse", {31'd0, sec_pulse}, 32'd0);
    rst_n = 1'b1;

    // 12 idle cycles: one advance every 4th edge
    for (int k = 1; k <= 12; k++)
      add(1'b0, 1'b0, 24'(k / 4), 3'b000, (k % 4) == 0);
    add(1'b1, 1'b0, 24'h000003, 3'b100, 1'b0);
    add(1'b0, 1'b1, 24'h010003, 3'b100, 1'b0);
    add(1'b0, 1'b0, 24'h010003, 3'b100, 1'b0);
    add(1'b1, 1'b1, 24'h010003, 3'b010, 1'b0);
    add(1'b0, 1'b1, 24'h010103, 3'b010, 1'b0);
    add(1'b1, 1'b0, 24'h010103, 3'b001, 1'b0);
    add(1'b0, 1'b1, 24'h010104, 3'b001, 1'b0);
    add(1'b0, 1'b0, 24'h010104, 3'b001, 1'b0);
    add(1'b1, 1'b0, 24'h010104, 3'b000, 1'b0);
    add(1'b0, 1'b0, 24'h010104, 3'b000, 1'b0);
    add(1'b0, 1'b0, 24'h010104, 3'b000, 1'b0);
    add(1'b0, 1'b0, 24'h010104, 3'b000, 1'b0);
    add(1'b0, 1'b0, 24'h010105, 3'b000, 1'b1);
    add(1'b0, 1'b1, 24'h010105, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      cyc(vecs[i].mode, vecs[i].inc);
      check($sformatf("vec%0d_time", i),  {8'd0, cur_time}, {8'd0, vecs[i].t});
      check($sformatf("vec%0d_flash", i), {29'd0, flashes()}, {29'd0, vecs[i].fl});
      check($sformatf("vec%0d_pulse", i), {31'd0, sec_pulse}, {31'd0, vecs[i].p});
    end

    // 23:59:59 rollover
    do_reset();
    cyc(1'b1, 1'b0);
    incs(23);
    check("sethr_time", {8'd0, cur_time}, 32'h170000);
    cyc(1'b1, 1'b0);
    incs(59);
    cyc(1'b1, 1'b0);
    incs(59);
    check("sets_time",  {8'd0, cur_time}, 32'h173B3B);
    check("sets_flash", {29'd0, flashes()}, 32'd1);
    cyc(1'b1, 1'b0);
    check("exit_time",  {8'd0, cur_time}, 32'h173B3B);
    check("exit_flash", {29'd0, flashes()}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0);
      check("wrap_wait_time",  {8'd0, cur_time}, 32'h173B3B);
      check("wrap_wait_pulse", {31'd0, sec_pulse}, 32'd0);
    end
    cyc(1'b0, 1'b0);
    check("wrap_time",  {8'd0, cur_time}, 32'h000000);
    check("wrap_pulse", {31'd0, sec_pulse}, 32'd1);
    cyc(1'b0, 1'b0);
    check("wrap_pulse_one", {31'd0, sec_pulse}, 32'd0);

    // minute field wraps with no carry into hour
    do_reset();
    cyc(1'b1, 1'b0);
    incs(5);
    cyc(1'b1, 1'b0);
    incs(10);
    check("m_start_time",  {8'd0, cur_time}, 32'h050A00);
    check("m_start_flash", {29'd0, flashes()}, 32'd2);
    incs(60);
    check("m_60_time", {8'd0, cur_time}, 32'h050A00);
    incs(50);
    check("m_nocarry_time", {8'd0, cur_time}, 32'h050000);

    // reset mid-set
    do_reset();
    cyc(1'b1, 1'b0);
    incs(2);
    cyc(1'b1, 1'b0);
    incs(3);
    check("pre_rst_time", {8'd0, cur_time}, 32'h020300);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_time",  {8'd0, cur_time}, 32'd0);
    check("midrst_flash", {29'd0, flashes()}, 32'd0);
    check("midrst_pulse", {31'd0, sec_pulse}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("post_rst%0d_pulse", k), {31'd0, sec_pulse}, {31'd0, (k == 4)});
      check($sformatf("post_rst%0d_time", k),  {8'd0, cur_time}, (k == 4) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
